// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file arbiter.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   state_t                 : arbiter FSM state encoding
package rf_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick.
//   req0, req1 : requests
//   last       : requester granted most recently
//   winner     : chosen requester (0/1); meaningless when neither requests
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    // On a tie the requester that was not granted last wins; otherwise the
    // sole requester wins.
    assign winner = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/rf_arbiter.sv
// Arbitrates two requesters onto one single-port-write / single-port-read
// register file. Each operation takes IDLE -> ACCESS -> RESP.
//   clk, reset_n              : clock, synchronous active-low reset
//   req*/wr*/addr*/wdata*     : requester 0/1 operation inputs
//   ack0, ack1                : one-cycle completion pulses
//   rdata                     : last read result
//   busy                      : FSM not in IDLE
//   rf_we/rf_wAddr/rf_wData   : register-file write port
//   rf_rAddr/rf_rData         : register-file combinational read port
module rf_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wAddr,
    output logic [DATA_W-1:0] rf_wData,
    output logic [ADDR_W-1:0] rf_rAddr,
    input  logic [DATA_W-1:0] rf_rData
);

    state_t            state;
    logic              last;
    logic              winner;
    logic              id_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;

    rr_arbiter2 u_rr (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            last    <= 1'b1;
            id_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state   <= ACCESS;
                        busy    <= 1'b1;
                        last    <= winner;
                        id_q    <= winner;
                        wr_q    <= winner ? wr1 : wr0;
                        we_q    <= winner ? wr1 : wr0;
                        addr_q  <= winner ? addr1 : addr0;
                        wdata_q <= winner ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    we_q  <= 1'b0;
                    if (!wr_q)
                        rdata <= rf_rData;
                    ack0  <= ~id_q;
                    ack1  <= id_q;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The register file samples we at the ACCESS->RESP edge; masking with
    // reset_n keeps a write from landing when reset hits that same edge.
    assign rf_we    = we_q & reset_n;
    assign rf_wAddr = addr_q;
    assign rf_wData = wdata_q;
    assign rf_rAddr = addr_q;

endmodule
